// File: rtl/tdm_demux.sv
// TDM receiver: routes interleaved slot words to per-channel holding registers,
// tracks frame alignment from the slot-0 sync flag and recovers from sync faults.
module tdm_demux #(
  parameter int CH = 4,
  parameter int W  = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [W-1:0]    I,
  input  logic            I_valid,
  input  logic            S,
  output logic [CH*W-1:0] O,
  output logic [CH-1:0]   O_stb,
  output logic            frame_done,
  output logic            locked,
  output logic            sync_err
);

  localparam int CNTW = $clog2(CH);
  localparam logic [CNTW-1:0] CNT_LAST = CNTW'(CH - 1);

  typedef enum logic [0:0] {
    HUNT = 1'b0,
    LOCK = 1'b1
  } state_e;

  state_e          state_q, state_d;
  logic [CNTW-1:0] cnt_q, cnt_d;
  logic [CH*W-1:0] o_q, o_d;
  logic [CH-1:0]   o_stb_q, o_stb_d;
  logic            frame_done_q, frame_done_d;
  logic            locked_q, locked_d;
  logic            sync_err_q, sync_err_d;
  logic            wr_en;
  logic [CNTW-1:0] wr_idx;

  // Next-state: decide which channel (if any) this slot lands in and track alignment.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    frame_done_d = 1'b0;
    sync_err_d   = 1'b0;
    wr_en        = 1'b0;
    wr_idx       = '0;
    if (I_valid) begin
      case (state_q)
        HUNT: begin
          if (S) begin
            wr_en   = 1'b1;
            wr_idx  = '0;
            cnt_d   = CNTW'(1);
            state_d = LOCK;
          end else begin
            state_d = HUNT;
          end
        end
        LOCK: begin
          if (S) begin
            // An early sync restarts the frame; the partial frame is abandoned.
            sync_err_d = (cnt_q != '0);
            wr_en      = 1'b1;
            wr_idx     = '0;
            cnt_d      = CNTW'(1);
          end else if (cnt_q == '0) begin
            sync_err_d = 1'b1;
            cnt_d      = '0;
            state_d    = HUNT;
          end else begin
            wr_en  = 1'b1;
            wr_idx = cnt_q;
            if (cnt_q == CNT_LAST) begin
              frame_done_d = 1'b1;
              cnt_d        = '0;
            end else begin
              cnt_d = cnt_q + CNTW'(1);
            end
          end
        end
        default: begin
          state_d = HUNT;
          cnt_d   = '0;
        end
      endcase
    end else begin
      state_d = state_q;
    end
    locked_d = (state_d == LOCK);
  end

  // Write decode: one strobe per accepted slot, unwritten channels hold.
  always_comb begin
    o_d     = o_q;
    o_stb_d = '0;
    for (int k = 0; k < CH; k++) begin
      o_stb_d[k]    = wr_en && (wr_idx == CNTW'(k));
      o_d[k*W +: W] = o_stb_d[k] ? I : o_q[k*W +: W];
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= HUNT;
      cnt_q        <= '0;
      o_q          <= '0;
      o_stb_q      <= '0;
      frame_done_q <= 1'b0;
      locked_q     <= 1'b0;
      sync_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      o_q          <= o_d;
      o_stb_q      <= o_stb_d;
      frame_done_q <= frame_done_d;
      locked_q     <= locked_d;
      sync_err_q   <= sync_err_d;
    end
  end

  assign O          = o_q;
  assign O_stb      = o_stb_q;
  assign frame_done = frame_done_q;
  assign locked     = locked_q;
  assign sync_err   = sync_err_q;

endmodule

// File: tb/tb_tdm_demux.sv
// Scoreboard bench for tdm_demux: a frame-level reference model queues expected
// events at stimulus time; a negedge monitor pops and compares on every DUT event.
module tb_tdm_demux;
  localparam int CH = 4;
  localparam int W  = 8;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [W-1:0]    I;
  logic            I_valid;
  logic            S;
  logic [CH*W-1:0] O;
  logic [CH-1:0]   O_stb;
  logic            frame_done;
  logic            locked;
  logic            sync_err;

  always #5 clk = ~clk;

  tdm_demux #(.CH(CH), .W(W)) dut (
    .clk(clk), .rst_n(rst_n), .I(I), .I_valid(I_valid), .S(S),
    .O(O), .O_stb(O_stb), .frame_done(frame_done), .locked(locked), .sync_err(sync_err)
  );

  typedef struct packed {
    logic [CH-1:0]   stb;
    logic            fd;
    logic            err;
    logic            lk;
    logic [CH*W-1:0] o;
  } ev_t;

  ev_t          q[$];
  ev_t          last;
  ev_t          e;
  int           checks = 0;
  int           errors = 0;

  logic [W-1:0] m_ch[CH];
  bit           m_locked;
  int           m_pos;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [CH*W-1:0] m_image();
    logic [CH*W-1:0] r;
    for (int k = 0; k < CH; k++) r[k*W +: W] = m_ch[k];
    return r;
  endfunction

  task automatic model_push(input logic [CH-1:0] stb, input bit fd, input bit err);
    ev_t x;
    x.stb = stb;
    x.fd  = fd;
    x.err = err;
    x.lk  = m_locked;
    x.o   = m_image();
    q.push_back(x);
  endtask

  // Reference model: what one accepted word does to the frame.
  task automatic model_step(input bit v, input bit s, input logic [W-1:0] d);
    logic [CH-1:0] stb;
    bit fd;
    bit err;
    if (!rst_n || !v) return;
    stb = '0;
    fd  = 1'b0;
    err = 1'b0;
    if (!m_locked) begin
      if (!s) return;
      m_ch[0] = d; m_pos = 1; m_locked = 1'b1; stb[0] = 1'b1;
    end else if (s) begin
      err = (m_pos != 0);
      m_ch[0] = d; m_pos = 1; stb[0] = 1'b1;
    end else if (m_pos == 0) begin
      err = 1'b1; m_locked = 1'b0;
    end else begin
      m_ch[m_pos] = d; stb[m_pos] = 1'b1;
      fd = (m_pos == CH - 1);
      m_pos = (m_pos + 1) % CH;
    end
    model_push(stb, fd, err);
  endtask

  task automatic drive(input bit v, input bit s, input logic [W-1:0] d);
    @(posedge clk);
    #2;
    I_valid = v;
    S       = s;
    I       = d;
    model_step(v, s, d);
  endtask

  task automatic frame(input logic [W-1:0] b0, input logic [W-1:0] b1,
                       input logic [W-1:0] b2, input logic [W-1:0] b3);
    drive(1'b1, 1'b1, b0);
    drive(1'b1, 1'b0, b1);
    drive(1'b1, 1'b0, b2);
    drive(1'b1, 1'b0, b3);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    chk("async_clear_O", O, '0);
    chk("async_clear_flags", {O_stb, frame_done, locked, sync_err}, '0);
    for (int k = 0; k < CH; k++) m_ch[k] = '0;
    m_locked = 1'b0;
    m_pos    = 0;
    q.delete();
    for (int i = 0; i < 3; i++) drive(i[0], 1'b1, W'($urandom));
    @(posedge clk);
    #1;
    I_valid = 1'b0;
    S       = 1'b0;
    rst_n   = 1'b1;
  endtask

  // Monitor: pop on every DUT event, otherwise outputs must hold.
  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_O", O, '0);
      chk("rst_flags", {O_stb, frame_done, locked, sync_err}, '0);
      last = '0;
    end else if (O_stb != '0 || sync_err || frame_done) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_event: got stb=%b fd=%b err=%b expected none at %0t",
                 O_stb, frame_done, sync_err, $time);
      end else begin
        e = q.pop_front();
        chk("O_stb", O_stb, e.stb);
        chk("frame_done", frame_done, e.fd);
        chk("sync_err", sync_err, e.err);
        chk("locked", locked, e.lk);
        chk("O", O, e.o);
        last = e;
      end
    end else begin
      chk("idle_O", O, last.o);
      chk("idle_locked", locked, last.lk);
    end
  end

  initial begin
    rst_n   = 1'b1;
    I       = '0;
    I_valid = 1'b0;
    S       = 1'b0;
    last    = '0;
    #1;
    do_reset();

    // Reset then lock, back-to-back.
    frame(8'h11, 8'h22, 8'h33, 8'h44);

    // HUNT discard after a fresh reset.
    drive(1'b0, 1'b0, 8'h00);
    @(negedge clk);
    #1;
    do_reset();
    drive(1'b1, 1'b0, 8'hAA);
    drive(1'b1, 1'b0, 8'hBB);
    frame(8'h01, 8'h02, 8'h03, 8'h04);

    // Gapped frame; S without valid in the gap is ignored.
    drive(1'b1, 1'b1, 8'hA0);
    drive(1'b1, 1'b0, 8'hA1);
    drive(1'b0, 1'b1, 8'hFF);
    drive(1'b0, 1'b0, 8'hEE);
    drive(1'b1, 1'b0, 8'hA2);
    drive(1'b1, 1'b0, 8'hA3);

    // Early sync, then finish the restarted frame.
    drive(1'b1, 1'b1, 8'h10);
    drive(1'b1, 1'b0, 8'h20);
    drive(1'b1, 1'b1, 8'h30);
    drive(1'b1, 1'b0, 8'h40);
    drive(1'b1, 1'b0, 8'h50);
    drive(1'b1, 1'b0, 8'h60);

    // Missing sync after a complete frame, then relock.
    drive(1'b1, 1'b0, 8'h55);
    drive(1'b0, 1'b0, 8'h00);
    frame(8'hC0, 8'hC1, 8'hC2, 8'hC3);

    // Reset mid-frame after ch1; next non-S word must be discarded.
    drive(1'b1, 1'b1, 8'h71);
    drive(1'b1, 1'b0, 8'h72);
    drive(1'b0, 1'b0, 8'h00);
    @(negedge clk);
    #1;
    do_reset();
    drive(1'b1, 1'b0, 8'h99);
    frame(8'hD0, 8'hD1, 8'hD2, 8'hD3);

    // Randomized traffic.
    for (int i = 0; i < 400; i++)
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 4) == 0, W'($urandom));

    for (int i = 0; i < 4; i++) drive(1'b0, 1'b0, 8'h00);
    chk("queue_drained", 128'(q.size()), '0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/tdm_demux.md
Name: tdm_demux

Overview:
- Receiver end of the team's time-division mux path: takes a word stream in which CH channels are interleaved slot-by-slot, with slot 0 marked by a frame-sync flag.
- Routes each slot to its own per-channel holding register; frame-sync loss or misalignment is detected and recovered.
- Sits after the mux/serialiser stage and feeds per-channel consumers, which read registered outputs plus strobes.

Parameters:
- CH, 4, number of interleaved channels (2..16).
- W, 8, data width of one slot word.
- CNTW, $clog2(CH), slot counter width (derived, not overridden).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- I  input  W  slot data word.
- I_valid  input  1  I carries a slot this cycle.
- S  input  1  frame sync; qualified by I_valid; high only on slot 0.
- O  output  CH*W  per-channel registers; channel k at O[k*W +: W].
- O_stb  output  CH  one-cycle pulse, bit k = channel k updated this cycle.
- frame_done  output  1  one-cycle pulse when the last channel of a frame is written.
- locked  output  1  demux is aligned to the frame.
- sync_err  output  1  one-cycle pulse on sync misalignment or loss.

Behaviour:
- Reset, asynchronous on rst_n low: O=0, O_stb=0, frame_done=0, locked=0, sync_err=0, slot counter=0, state HUNT.
- All outputs are registered. Latency is one cycle: a slot accepted at edge n appears on O and O_stb after edge n.
- Cycles with I_valid=0 change nothing except clearing the pulse outputs. The counter holds, so gaps inside a frame are legal.
- HUNT, locked=0:
  - I_valid & !S: word discarded, no strobe.
  - I_valid & S: write channel 0, pulse O_stb[0], counter=1, go LOCK.
- LOCK, locked=1, on I_valid:
  - counter!=0 & !S: write channel counter, pulse O_stb[counter]. If counter==CH-1, pulse frame_done and set counter=0; otherwise increment.
  - counter!=0 & S (early sync): pulse sync_err, treat word as slot 0 (write ch0, O_stb[0], counter=1), stay LOCK. The partial frame gives no frame_done.
  - counter==0 & S: normal frame start; write ch0, counter=1.
  - counter==0 & !S (missing sync): pulse sync_err, discard word, counter=0, go HUNT, locked=0 on the next edge.
- Sync error pulse and strobe may assert in the same cycle (early-sync case).
- Channels not written hold their last value across frames, errors and HUNT.
- At most one O_stb bit is high per cycle.
- frame_done is only ever coincident with O_stb[CH-1].
- S without I_valid is ignored.
- Reset mid-frame aborts immediately. The first post-reset frame must start with S.
- Counter wraps from CH-1 to 0 exactly; no out-of-range channel index is ever produced. For non-power-of-two CH, counter values >= CH are unreachable.

Test Plan:
- Reset then lock: rst_n low 3 cycles with I_valid toggling. Then slots 11,22,33,44 with S on the first, back-to-back.
  - Every output stays 0 throughout reset.
  - O_stb = 0001,0010,0100,1000 on successive cycles; O = {44,33,22,11}.
  - frame_done pulses with O_stb=1000; locked=1 from the cycle after the first slot.
- HUNT discard: slots 0xAA,0xBB without S, then a frame starting 0x01 with S.
  - No strobe and O unchanged for the unsynced words; the lock sequence proceeds as in scenario 1.
- Gapped frame: the same 4 slots with I_valid=0 for 2 cycles between slot 1 and slot 2.
  - Strobes appear only on valid cycles; frame_done still fires with ch3; the counter holds through the gap.
- Early sync: after slots ch0,ch1 (0x10,0x20), send 0x30 with S.
  - sync_err and O_stb[0] pulse together, ch0=0x30, ch1 keeps 0x20, no frame_done, locked stays 1.
- Missing sync: complete a frame, then send 0x55 without S.
  - sync_err pulses, locked=0, no strobe, O unchanged. A following S-marked frame relocks normally.
- Reset mid-frame: assert rst_n low after slot ch1.
  - All outputs clear asynchronously, before the next clk edge. After release, the next non-S word is discarded.
